// File: rtl/fc_input_buffer.sv
// fc_input_buffer
//   Serial-to-parallel activation collector feeding the fully-connected layer.
//   Accepts one WIDTH-bit activation per cycle over valid/ready, stores IN of
//   them, then presents the frame as an unpacked vector held stable until the
//   consumer takes it.
//
// Optional feature: define FC_BUF_LAST_CHECK_EN to check i_in_last framing.
//   Defined   : a beat whose i_in_last disagrees with its position is written,
//               but the frame is dropped and o_frame_err pulses for one cycle.
//   Undefined : i_in_last ignored, framing purely by count, o_frame_err = 0.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_in_data      activation beat
//   i_in_valid     i_in_data valid
//   i_in_last      final beat of frame marker
//   o_in_ready     buffer accepts a beat this cycle
//   o_x_out        assembled vector [0:IN-1]
//   o_out_valid    o_x_out holds a complete frame
//   i_out_ready    consumer takes the frame
//   o_fill_level   beats accepted in current frame (IN while full)
//   o_frame_err    one-cycle pulse, frame dropped
module fc_input_buffer #(
    parameter int WIDTH = 8,
    parameter int IN    = 400
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic                     i_in_valid,
    input  logic                     i_in_last,
    output logic                     o_in_ready,
    output logic [WIDTH-1:0]         o_x_out [0:IN-1],
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [$clog2(IN+1)-1:0]  o_fill_level,
    output logic                     o_frame_err
);

    localparam int PW = (IN > 1) ? $clog2(IN) : 1;
    localparam int FW = $clog2(IN + 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [WIDTH-1:0] r_mem [0:IN-1];
    logic             r_frame_err;

    logic             w_accept;
    logic             w_at_end;
    logic             w_viol;

    assign w_at_end = (r_wr_ptr == PW'(IN - 1));

`ifdef FC_BUF_LAST_CHECK_EN
    // i_in_last must be high exactly on the beat landing at the final slot.
    assign w_viol = w_accept && (i_in_last != w_at_end);
`else
    logic w_unused_last;
    assign w_unused_last = i_in_last;
    assign w_viol        = 1'b0;
`endif

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            FILL: begin
                // Ready is suppressed during reset so no beat is consumed then.
                o_in_ready = !i_rst;
                w_accept   = i_in_valid && !i_rst;
                if (w_accept) begin
                    if (w_viol) begin
                        w_wr_ptr_nxt = '0;
                    end else if (w_at_end) begin
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = FULL;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
                    end
                end
            end
            FULL: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= FILL;
            r_wr_ptr    <= '0;
            r_frame_err <= 1'b0;
            for (int unsigned i = 0; i < IN; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_frame_err <= w_viol;
            // A violating beat is still written; the next frame overwrites it.
            if (w_accept) begin
                r_mem[r_wr_ptr] <= i_in_data;
            end
        end
    end

    assign o_x_out      = r_mem;
    assign o_frame_err  = r_frame_err;
    assign o_fill_level = (r_state == FULL) ? FW'(IN) : FW'(r_wr_ptr);

endmodule

// File: tb/tb_fc_input_buffer.sv
module tb_fc_input_buffer;

    localparam int WIDTH = 8;
    localparam int IN    = 400;
    localparam int FW    = $clog2(IN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] x_out [0:IN-1];
    logic             out_valid;
    logic             out_ready;
    logic [FW-1:0]    fill_level;
    logic             frame_err;

    fc_input_buffer #(.WIDTH(WIDTH), .IN(IN)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .i_in_last    (in_last),
        .o_in_ready   (in_ready),
        .o_x_out      (x_out),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_fill_level (fill_level),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: frame contents as a queue, the visible vector as an array.
    bit               m_full;
    bit               m_err;
    bit               m_acc;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_x [IN];

    // Phase-7 bookkeeping
    bit track_ov = 0;
    int ov_cycles[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        int bad_i = -1;
        chk("in_ready", 32'(in_ready), 32'(!m_full && !rst));
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("fill_level", 32'(fill_level), m_full ? 32'(IN) : 32'(q.size()));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        for (int i = 0; i < IN; i++) begin
            if (x_out[i] !== m_x[i]) begin
                bad_i = i;
                break;
            end
        end
        if (bad_i < 0) chk("x_out", 32'(x_out[0]), 32'(m_x[0]));
        else           chk($sformatf("x_out[%0d]", bad_i), 32'(x_out[bad_i]), 32'(m_x[bad_i]));
        if (track_ov && out_valid === 1'b1) ov_cycles.push_back(cyc);
    endtask

    // One clock: inputs are already driven; update model from them, then check.
    task automatic step();
        bit acc;
        bit viol;
        @(posedge clk);
        cyc++;
        m_acc = 0;
        if (rst) begin
            m_full = 0;
            m_err  = 0;
            q.delete();
            foreach (m_x[i]) m_x[i] = '0;
        end else begin
            acc   = in_valid && !m_full;
            m_err = 0;
            if (m_full && out_ready) m_full = 0;
            if (acc) begin
                m_x[q.size()] = in_data;
                q.push_back(in_data);
`ifdef FC_BUF_LAST_CHECK_EN
                viol = (in_last != (q.size() == IN));
`else
                viol = 0;
`endif
                if (viol) begin
                    q.delete();
                    m_err = 1;
                end else if (q.size() == IN) begin
                    m_full = 1;
                    q.delete();
                end
            end
            m_acc = acc;
        end
        #1;
        check_outputs();
    endtask

    // Holds a beat until accepted; in_last follows position, inverted if bad.
    task automatic send_beat(input logic [WIDTH-1:0] d, input bit bad);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 1000; t++) begin
            in_last = ((m_full ? 0 : q.size()) == IN - 1) ^ bad;
            step();
            if (m_acc) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset
        step();
        step();
        rst = 1'b0;
        idle(1);

        // Full frame, back-to-back, consumer not ready
        for (int i = 0; i < IN; i++) send_beat(WIDTH'(i & 8'hFF), 1'b0);
        chk("full_after_frame1", 32'(out_valid), 32'd1);

        // Hold in FULL with pending 0xAA beats, then handshake
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 10; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();

        // Valid toggling every other cycle
        for (int i = 0; i < IN; i++) begin
            idle(1);
            send_beat(WIDTH'($urandom_range(0, 255)), 1'b0);
        end
        chk("full_after_toggle", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();

        // Framing error on beat 100, then a clean frame
        for (int i = 0; i < 100; i++) send_beat(WIDTH'($urandom_range(0, 255)), 1'b0);
        send_beat(WIDTH'($urandom_range(0, 255)), 1'b1);
        for (int i = 0; i < IN; i++) send_beat(WIDTH'($urandom_range(0, 255)), 1'b0);
        idle(2);
        out_ready = 1'b0;

        // Reset mid-fill, then a 0x5A frame
        for (int i = 0; i < 200; i++) send_beat(WIDTH'($urandom_range(0, 255)), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < IN; i++) send_beat(8'h5A, 1'b0);
        chk("x_out_5a_last", 32'(x_out[IN-1]), 32'h5A);
        out_ready = 1'b1;
        step();

        // Consumer always ready, two continuous frames
        track_ov = 1;
        for (int i = 0; i < 2 * IN; i++) send_beat(WIDTH'($urandom_range(0, 255)), 1'b0);
        step();
        track_ov = 0;
        chk("ov_count", 32'(ov_cycles.size()), 32'd2);
        if (ov_cycles.size() == 2)
            chk("frame_period", 32'(ov_cycles[1] - ov_cycles[0]), 32'd401);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = WIDTH'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) == 0);
            in_last   = ((m_full ? 0 : q.size()) == IN - 1) ^ ($urandom_range(0, 63) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
